// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM state encoding,
// port identifiers and default geometry.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic PORT_P = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEFAULT_ADDR_W    = 24;
  localparam int DEFAULT_BURST_LEN = 4;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the program-cache, data-cache and SDRAM-controller signals seen by
// the arbiter; master is the arbiter's view, slave is the surrounding system.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
);

  logic              p_req;
  logic [ADDR_W-1:0] p_addr;
  logic [15:0]       p_rdata;
  logic              p_rvalid;
  logic              p_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_wdata;
  logic              d_wready;
  logic [15:0]       d_rdata;
  logic              d_rvalid;
  logic              d_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_wdata;
  logic              mem_wready;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;

  logic              busy;
  logic [1:0]        grant;
  logic              proto_err;

  modport master (
    input  p_req, p_addr,
    output p_rdata, p_rvalid, p_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_wready, d_rdata, d_rvalid, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_wready, mem_rdata, mem_rvalid,
    output busy, grant, proto_err
  );

  modport slave (
    output p_req, p_addr,
    input  p_rdata, p_rvalid, p_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_wready, d_rdata, d_rvalid, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_wready, mem_rdata, mem_rvalid,
    input  busy, grant, proto_err
  );

endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between the program
// cache (fills) and the data cache (fills and write-backs), one burst per grant.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_port_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_CMD     = CMD;
  localparam logic [1:0] ST_XFER    = XFER;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  logic [1:0]        state;
  logic              last_port;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       p_rdata_q, d_rdata_q;
  logic              p_rvalid_q, d_rvalid_q;
  logic              p_done_q, d_done_q;
  logic              proto_err_q;

  logic in_cmd, in_xfer, rd_xfer, wr_xfer;
  logic pick_d, granted_req, final_beat, violation;

  assign in_cmd  = (state == ST_CMD);
  assign in_xfer = (state == ST_XFER);
  assign rd_xfer = in_xfer & ~we_q;
  assign wr_xfer = in_xfer &  we_q;

  // Data wins when it asks alone, or on a tie when program was served last.
  assign pick_d      = bus.d_req & (~bus.p_req | (last_port == PORT_P));
  assign granted_req = (port_q == PORT_D) ? bus.d_req : bus.p_req;
  assign final_beat  = (cnt == LAST_BEAT);

  // The requester may only drop req once done is visible, i.e. in RELEASE.
  assign violation = (bus.mem_rvalid & ~rd_xfer)
                   | (bus.mem_wready & ~wr_xfer)
                   | (bus.mem_ack    & ~in_cmd)
                   | ((in_cmd | in_xfer) & ~granted_req);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_port   <= PORT_P;
      port_q      <= PORT_P;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cnt         <= '0;
      // NOTE: the rdata holding registers are reset as well because they are
      // visible outputs that must read 0 while reset is asserted.
      p_rdata_q   <= '0;
      d_rdata_q   <= '0;
      p_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      p_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      p_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      p_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      if (violation) proto_err_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.p_req | bus.d_req) begin
            port_q <= pick_d;
            we_q   <= pick_d & bus.d_we;
            addr_q <= pick_d ? bus.d_addr : bus.p_addr;
            state  <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.mem_ack) begin
            cnt       <= '0;
            last_port <= port_q;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!we_q) begin
            if (bus.mem_rvalid) begin
              cnt <= cnt + 1'b1;
              if (port_q == PORT_D) begin
                d_rdata_q  <= bus.mem_rdata;
                d_rvalid_q <= 1'b1;
                d_done_q   <= final_beat;
              end else begin
                p_rdata_q  <= bus.mem_rdata;
                p_rvalid_q <= 1'b1;
                p_done_q   <= final_beat;
              end
              if (final_beat) state <= ST_RELEASE;
            end
          end else if (bus.mem_wready) begin
            cnt <= cnt + 1'b1;
            if (final_beat) begin
              d_done_q <= 1'b1;
              state    <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.grant     = (state == ST_IDLE) ? 2'b00
                       : ((port_q == PORT_D) ? 2'b10 : 2'b01);
  assign bus.proto_err = proto_err_q;

  assign bus.mem_req   = in_cmd;
  assign bus.mem_we    = in_cmd & we_q;
  assign bus.mem_addr  = in_cmd ? addr_q : '0;
  assign bus.mem_wdata = wr_xfer ? bus.d_wdata : 16'h0000;
  assign bus.d_wready  = wr_xfer & bus.mem_wready;

  assign bus.p_rdata   = p_rdata_q;
  assign bus.p_rvalid  = p_rvalid_q;
  assign bus.p_done    = p_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_done    = d_done_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus pushes expected commands
// and beats into queues, a negedge monitor pops and compares them.
module tb_sdram_port_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sdram_port_arbiter_if #(.ADDR_W(24)) bus ();

  sdram_port_arbiter #(.ADDR_W(24), .BURST_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [1:0]  grant;
  } cmd_t;

  beat_t p_exp[$];
  beat_t d_exp[$];
  beat_t w_exp[$];
  cmd_t  cmd_exp[$];
  logic  wlast_pend = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk_cmd(input logic we, input logic [23:0] addr, input logic [1:0] grant);
    cmd_t c;
    c.we = we; c.addr = addr; c.grant = grant;
    return c;
  endfunction

  task automatic push_read(input bit to_d, input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = base + 16'(i);
      b.last = (i == 3);
      if (to_d) d_exp.push_back(b);
      else      p_exp.push_back(b);
    end
  endtask

  task automatic check_quiet_outputs(input string name);
    check({name, "_ctrl"}, {bus.busy, bus.grant, bus.mem_req, bus.mem_we, bus.p_rvalid,
                            bus.p_done, bus.d_rvalid, bus.d_done, bus.d_wready, bus.proto_err}, 64'd0);
    check({name, "_data"}, {bus.p_rdata, bus.d_rdata, bus.mem_wdata}, 64'd0);
    check({name, "_addr"}, bus.mem_addr, 64'd0);
  endtask

  task automatic wait_mem_req();
    int n = 0;
    while (!bus.mem_req && n < 50) begin
      tick();
      n++;
    end
    check("mem_req_seen", bus.mem_req, 1);
  endtask

  task automatic serve_read(input int delay, input logic [15:0] base, input int nbeats);
    wait_mem_req();
    repeat (delay) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + 16'(i);
      tick();
    end
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic serve_write(input int delay, input logic [63:0] words);
    wait_mem_req();
    repeat (delay) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.d_wdata    = words[i*16 +: 16];
      bus.mem_wready = 1'b1;
      tick();
      bus.mem_wready = 1'b0;
      if (i < 3) tick();
    end
  endtask

  // Monitor: consumes every output event the DUT presents.
  always @(negedge clk) begin : monitor
    beat_t b;
    cmd_t  c;
    logic  ep, ed;
    if (reset) begin
      wlast_pend = 1'b0;
    end else begin
      if (bus.mem_req) begin
        if (cmd_exp.size() == 0) begin
          check("mem_req_spurious", bus.mem_req, 0);
        end else begin
          c = cmd_exp[0];
          check("cmd_we", bus.mem_we, c.we);
          check("cmd_addr", bus.mem_addr, c.addr);
          check("cmd_grant", bus.grant, c.grant);
          if (bus.mem_ack) void'(cmd_exp.pop_front());
        end
      end

      ep = 1'b0;
      ed = wlast_pend;
      wlast_pend = 1'b0;

      if (bus.p_rvalid) begin
        if (p_exp.size() == 0) check("p_rvalid_spurious", bus.p_rvalid, 0);
        else begin
          b = p_exp.pop_front();
          check("p_rdata", bus.p_rdata, b.data);
          ep = b.last;
        end
      end

      if (bus.d_rvalid) begin
        if (d_exp.size() == 0) check("d_rvalid_spurious", bus.d_rvalid, 0);
        else begin
          b = d_exp.pop_front();
          check("d_rdata", bus.d_rdata, b.data);
          ed = ed | b.last;
        end
      end

      if (bus.d_wready) begin
        if (w_exp.size() == 0) check("d_wready_spurious", bus.d_wready, 0);
        else begin
          b = w_exp.pop_front();
          check("mem_wdata", bus.mem_wdata, b.data);
          wlast_pend = b.last;
        end
      end

      if (bus.p_done || ep) check("p_done", bus.p_done, ep);
      if (bus.d_done || ed) check("d_done", bus.d_done, ed);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [63:0] wr_words;
    int gap;

    bus.p_req = 0; bus.p_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_wready = 0; bus.mem_rdata = '0; bus.mem_rvalid = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet_outputs("reset");
    reset = 1'b0;
    tick();

    // Lone program fill
    bus.p_addr = 24'h000100;
    bus.p_req  = 1'b1;
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000100, 2'b01));
    push_read(1'b0, 16'hA000, 4);
    serve_read(3, 16'hA000, 4);
    bus.p_req = 1'b0;
    tick();
    check("t1_proto_err", bus.proto_err, 0);
    check("t1_d_rdata", bus.d_rdata, 0);

    // Data write-back with mem_wready on alternate cycles
    wr_words   = {16'h8001, 16'h1234, 16'hBEEF, 16'hC0DE};
    bus.d_addr = 24'h000200;
    bus.d_we   = 1'b1;
    bus.d_req  = 1'b1;
    cmd_exp.push_back(mk_cmd(1'b1, 24'h000200, 2'b10));
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.data = wr_words[i*16 +: 16];
      b.last = (i == 3);
      w_exp.push_back(b);
    end
    serve_write(1, wr_words);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    check("t2_proto_err", bus.proto_err, 0);

    // Simultaneous requests after reset: D, P, D, P
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.p_addr = 24'h000400;
    bus.d_addr = 24'h000300;
    bus.p_req  = 1'b1;
    bus.d_req  = 1'b1;
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000300, 2'b10));
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000400, 2'b01));
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000300, 2'b10));
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000400, 2'b01));
    push_read(1'b1, 16'hD000, 4);
    push_read(1'b0, 16'hB000, 4);
    push_read(1'b1, 16'hD100, 4);
    push_read(1'b0, 16'hB100, 4);
    serve_read(2, 16'hD000, 4);
    serve_read(0, 16'hB000, 4);
    serve_read(1, 16'hD100, 4);
    serve_read(0, 16'hB100, 4);
    bus.p_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    check("t3_proto_err", bus.proto_err, 0);

    // Stray mem_rvalid in IDLE
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hDEAD;
    tick();
    bus.mem_rvalid = 1'b0;
    check("stray_proto_err", bus.proto_err, 1);
    check("stray_busy", bus.busy, 0);
    tick();
    check("stray_still_idle", bus.busy, 0);
    check("stray_sticky", bus.proto_err, 1);
    reset = 1'b1;
    #1;
    check("proto_err_cleared", bus.proto_err, 0);
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-read after two beats
    bus.p_addr = 24'h000500;
    bus.p_req  = 1'b1;
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000500, 2'b01));
    push_read(1'b0, 16'hE000, 2);
    serve_read(1, 16'hE000, 2);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    bus.p_req = 1'b0;
    #1;
    check_quiet_outputs("mid_reset");
    tick();
    reset = 1'b0;
    tick();
    bus.p_addr = 24'h000600;
    bus.p_req  = 1'b1;
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000600, 2'b01));
    push_read(1'b0, 16'hF000, 4);
    serve_read(2, 16'hF000, 4);
    bus.p_req = 1'b0;
    tick();
    check("t5_proto_err", bus.proto_err, 0);

    // Back-to-back program fills: p_done to next mem_req
    bus.p_addr = 24'h000700;
    bus.p_req  = 1'b1;
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000700, 2'b01));
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000700, 2'b01));
    push_read(1'b0, 16'h7000, 4);
    push_read(1'b0, 16'h7100, 4);
    serve_read(0, 16'h7000, 4);
    check("b2b_done_seen", bus.p_done, 1);
    gap = 0;
    while (!bus.mem_req && gap < 10) begin
      tick();
      gap++;
    end
    check("b2b_gap", gap, 2);
    serve_read(0, 16'h7100, 4);
    bus.p_req = 1'b0;
    tick();
    check("t6_proto_err", bus.proto_err, 0);

    // mem_ack and mem_rvalid together: rvalid ignored and flagged
    bus.p_addr = 24'h000800;
    bus.p_req  = 1'b1;
    cmd_exp.push_back(mk_cmd(1'b0, 24'h000800, 2'b01));
    push_read(1'b0, 16'h8000, 4);
    wait_mem_req();
    bus.mem_ack    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hBAD0;
    tick();
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    check("ack_rvalid_proto_err", bus.proto_err, 1);
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 16'h8000 + 16'(i);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.p_req      = 1'b0;
    repeat (2) tick();

    check("p_exp_drained", p_exp.size(), 0);
    check("d_exp_drained", d_exp.size(), 0);
    check("w_exp_drained", w_exp.size(), 0);
    check("cmd_exp_drained", cmd_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller command/data port between the NeonFox program cache (line fills) and the data cache (line fills and write-backs). It grants one requester at a time using round-robin between the two ports, sequences one burst per grant, steers burst data between the controller and the granted cache, and signals completion. It sits between the two cache controllers and the SDRAM controller.

## Interface
- `ADDR_W`, default 24: SDRAM word address width.
- `BURST_LEN`, default 4: 16-bit words per burst; a power of two, at least 2.
- `clk` in 1: clock. Reset is `reset`, asynchronous, active-high; the clock is `clk`.
- `reset` in 1: asynchronous, active-high.
- `p_req` in 1: program-cache fill request. Held until `p_done`.
- `p_addr` in ADDR_W: burst start address. Stable while `p_req` is high.
- `p_rdata` out 16: fill data to the program cache.
- `p_rvalid` out 1: `p_rdata` is valid.
- `p_done` out 1: one-cycle pulse; the burst is complete.
- `d_req` in 1: data-cache request. Held until `d_done`.
- `d_we` in 1: 1 = write-back, 0 = fill. Stable while `d_req` is high.
- `d_addr` in ADDR_W: burst start address.
- `d_wdata` in 16: write-back word, presented before `d_wready`.
- `d_wready` out 1: the current `d_wdata` word is consumed this cycle.
- `d_rdata` out 16: fill data to the data cache.
- `d_rvalid` out 1: `d_rdata` is valid.
- `d_done` out 1: one-cycle completion pulse.
- `mem_req` out 1: command to the SDRAM controller. Held until `mem_ack`.
- `mem_we` out 1: command type.
- `mem_addr` out ADDR_W: command address.
- `mem_ack` in 1: one-cycle pulse; the command is accepted.
- `mem_wdata` out 16: write data to the controller.
- `mem_wready` in 1: the controller takes `mem_wdata` this cycle.
- `mem_rdata` in 16: read data from the controller.
- `mem_rvalid` in 1: `mem_rdata` is valid.
- `busy` out 1: the state is not IDLE.
- `grant` out 2: {data, program}. One-hot or zero.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- **States:** IDLE, CMD, XFER, RELEASE.
- **IDLE:**
  - If only one request is high, grant that port.
  - If both are high, grant the port not served last. The `last` register resets to program, so the first tie goes to data.
  - On a grant, latch the port, `we` (0 for program) and the address into registers, then go to CMD.
- **CMD:**
  - `mem_req`=1, with `mem_we`/`mem_addr` taken from the latched registers.
  - On `mem_ack`, clear the beat counter, update `last`, and go to XFER.
- **XFER, read:**
  - Each `mem_rvalid` increments the counter.
  - `mem_rdata` is registered into the granted port's `rdata`, and that port's `rvalid` is pulsed one cycle later. `rdata` holds its last value otherwise.
  - On the `BURST_LEN`-th beat, go to RELEASE. The registered `done` pulse coincides with the final `rvalid`.
- **XFER, write:**
  - `mem_wdata` = `d_wdata` (combinational).
  - `d_wready` = `mem_wready` (combinational, only in XFER with a write grant; 0 otherwise).
  - Each `mem_wready` increments the counter. The final beat goes to RELEASE, with `d_done` pulsing in the first RELEASE cycle.
- **RELEASE:** one cycle, with no arbitration, then IDLE. This lets the requester drop `req` after seeing `done`.
- **Counter:** width is clog2(`BURST_LEN`)+1 and it never wraps. Beats beyond `BURST_LEN` cannot occur because XFER is left on the final beat.
- **`proto_err`** is set by any of the following and is cleared only by reset:
  - `mem_rvalid` outside a read XFER;
  - `mem_wready` outside a write XFER;
  - `mem_ack` outside CMD;
  - the granted `req` dropping before `done`.
- **Protocol violations:** the state machine ignores the stray event, except a dropped request, which still completes the burst.
- **`mem_ack` and `mem_rvalid` in the same cycle:** the `rvalid` is illegal and flags `proto_err`.
- **Reset:** all outputs are 0, the state is IDLE, and `last` = program. Reset mid-burst abandons the burst; the SDRAM controller shares the same reset.

## Timing
- Request sampled high in IDLE at edge k: `grant`/`busy` high and `mem_req` high from cycle k+1.
- `mem_ack` at cycle m: XFER from m+1. The earliest `mem_rvalid` is counted at m+1.
- Read beat at cycle t: `rdata`/`rvalid` appear at t+1. For the last beat, `done` is also high at t+1.
- Write: `d_wready` has zero latency; last `mem_wready` at t gives `d_done` at t+1.
- Back-to-back grants: IDLE one cycle after RELEASE. The minimum gap between bursts is 2 cycles (RELEASE, IDLE).
- Throughput: one beat per cycle when the controller streams.

## Structure
- **Package `sdram_arb_pkg`:**
  - `arb_state_t` enum (IDLE, CMD, XFER, RELEASE);
  - port-id constants `PORT_P`=0 and `PORT_D`=1;
  - default `BURST_LEN`.
- **Single module, no sub-modules.** The round-robin pick is two gates.

## Test plan
- **Lone program fill:** `p_req` with addr 0x000100, controller acks after 3 cycles and returns 0xA000..0xA003 back-to-back → `mem_req`/`mem_we`=0/`mem_addr`=0x000100 held until ack; `p_rvalid` ×4 with data in order; `p_done` with the 4th beat; `d_*` outputs stay 0.
- **Data write-back:** `d_we`=1, `mem_wready` on alternate cycles → `d_wready` mirrors it exactly 4 times; `mem_wdata` equals the presented words; `d_done` one cycle after the 4th.
- **Simultaneous requests after reset:** data granted first, then program. With both held continuously, grants alternate D,P,D,P.
- **Stray `mem_rvalid` in IDLE:** `proto_err`=1, no `rvalid` output, state stays IDLE.
- **Reset asserted mid-read after 2 beats:** all outputs 0 immediately; after release a new `p_req` completes normally.
- **Back-to-back program fills:** measured gap from `p_done` to the next `mem_req` is exactly 2 cycles.
